vga_line_fetch: RTL and testbench
=================================

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 clock  in  1  single clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 pixPosX  in  12  current scan X from the VGA timing stage; values >= line width (incl. negative wrap 0xFxx) are off-screen.
REQ-004 pixPosY  in  12  current scan Y; same off-screen rule against line count.
REQ-005 ctrlRegVal  in  64  [0]=fetch enable, [3]=800x600 mode (else 640x480), [63:32]=framebuffer byte base (bits [2:0] ignored).
REQ-006 memReq  out  1  fetch request.
REQ-007 memAddr  out  32  fetch byte address; 8-byte aligned.
REQ-008 memAck  in  1  request accepted; memData valid this cycle.
REQ-009 memData  in  64  two pixels; each 32-bit half = {aux[7:0], V, U, Y}; low half = even pixel.
REQ-010 pixCy/pixCu/pixCv  out  8 each  pixel YUV to the VGA stage.
REQ-011 pixAux  out  16  {8'h0, aux[7:0]} of the pixel.
REQ-012 underrunCnt  out  16  saturating underrun counter.

Function
REQ-013 Two line buffers of 512x64 shall exist (front = scanned, back = fetched); width W=800/H=600 when ctrlRegVal[3]=1, else W=640/H=480; words per line S=W/2.
REQ-014 Each buffer shall carry a fill count (0..S) of words written from word 0 upward.
REQ-015 A line change is the cycle pixPosY differs from its registered previous value; on it front/back shall swap and a fetch of line N=(pixPosY+1) mod 4096 shall be scheduled if N<H, else none.
REQ-016 The swapped-in back buffer's fill count shall be cleared on swap.
REQ-017 Fetch FSM states IDLE, REQ, DONE: IDLE->REQ on scheduled fetch with enable=1; REQ holds memReq=1 with memAddr stable until memAck=1; DONE after word S-1 acked, DONE->IDLE next cycle.
REQ-018 memAddr = base + (N*S + w)*8 for word w; at most one word per memAck; back-to-back requests permitted (memReq may stay high across words).
REQ-019 On memAck the word shall be written to the buffer at w and its fill count incremented the same edge.
REQ-020 Line change during REQ: the current handshake shall complete (no request dropped while memReq=1 unacked), data land in its original buffer, then the FSM restarts for the new N.
REQ-021 Enable cleared during REQ: the outstanding handshake completes, then IDLE; no new fetch while enable=0.
REQ-022 Output latency 1 cycle: pixel for pixPosX presented on pixC*/pixAux the cycle after pixPosX is sampled.
REQ-023 Off-screen X or Y, or enable=0, shall output black: Y=0, U=V=128, aux=0.
REQ-024 On-screen X with word pixPosX>>1 >= front fill count shall output black and increment underrunCnt (saturates at 0xFFFF).
REQ-025 Line change and memAck in the same cycle: write goes to the pre-swap back buffer; swap applies after.

Reset
REQ-026 On reset: memReq=0, memAddr=0, pixCy=0, pixCu=pixCv=128, pixAux=0, underrunCnt=0, FSM=IDLE, front=buffer 0, both fill counts 0, previous pixPosY=0.
REQ-027 Reset asserted mid-handshake shall drop memReq asynchronously; buffer contents need not be cleared.

Configuration
REQ-028 Macro VGA_LINE_FETCH_UNDERRUN_EN: defined -> underrunCnt behaves per REQ-024; undefined -> counter logic absent, underrunCnt tied 0, black-on-underrun still applies.

Verification
REQ-029 640 mode, base 0x1000, pixPosY 0xFFF->0, memAck always 1 -> 320 requests, addresses 0x1008+... wait: line 1 at 0x1000+320*8=0x1A00..0x23F8, memReq drops after word 319.
REQ-030 Line 0 filled with pixel k={0,k,k,k}, pixPosX=5 -> next cycle pixCy=5, pixCu=5, pixCv=5, pixAux=0.
REQ-031 pixPosX=640 or 0xFFE -> Y=0, U=V=128, no underrunCnt change.
REQ-032 memAck held low, line change, pixPosX=0 scanned 10 cycles -> black output, underrunCnt=10 (0 with macro undefined).
REQ-033 pixPosY changes while memReq=1, memAck arrives 3 cycles later -> that word written to old buffer, next memAddr = base+(newN*S)*8.
REQ-034 800 mode, pixPosY=599 -> no fetch scheduled (N=600=H), memReq stays 0.

Source files
------------

// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: fetch-side memory handshake between the line fetcher and memory.
// The master side raises memReq and holds memAddr stable. The slave side answers
// with memAck, and memData is valid in the same cycle as memAck.
interface vga_line_fetch_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [63:0] memData;

  modport master (output memReq, output memAddr, input memAck, input memData);
  modport slave  (input memReq, input memAddr, output memAck, output memData);
endinterface

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: double-buffered scanline fetcher feeding the VGA pixel stage.
// One buffer (front) is scanned out while the other (back) is filled for the next line.
// Optional macro VGA_LINE_FETCH_UNDERRUN_EN enables the saturating underrun counter.
// When the macro is undefined, underrunCnt reads 0, but underrun pixels are still
// blanked.
//
// state    | meaning
// ST_IDLE  | no fetch in flight; waits for a scheduled line with enable set
// ST_REQ   | memReq high, memAddr held until memAck
// ST_DONE  | last word of the line accepted; back to idle next cycle
module vga_line_fetch (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      pixPosX,
  input  logic [11:0]      pixPosY,
  input  logic [63:0]      ctrlRegVal,
  vga_line_fetch_if.master mem,
  output logic [7:0]       pixCy,
  output logic [7:0]       pixCu,
  output logic [7:0]       pixCv,
  output logic [15:0]      pixAux,
  output logic [15:0]      underrunCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic        fetch_en;
  logic        mode_800;
  logic [31:0] fb_base;
  logic [11:0] line_w;
  logic [11:0] line_h;
  logic [9:0]  words_per_line;
  logic        unused_ctrl;

  assign fetch_en       = ctrlRegVal[0];
  assign mode_800       = ctrlRegVal[3];
  assign fb_base        = {ctrlRegVal[63:35], 3'b000};
  assign line_w         = mode_800 ? 12'd800 : 12'd640;
  assign line_h         = mode_800 ? 12'd600 : 12'd480;
  assign words_per_line = mode_800 ? 10'd400 : 10'd320;
  assign unused_ctrl    = ^{ctrlRegVal[34:32], ctrlRegVal[31:4], ctrlRegVal[2:1]};

  state_t      state_q, state_d;
  logic [11:0] prev_y_q, prev_y_d;
  logic        front_q, front_d;
  logic [9:0]  fill0_q, fill0_d;
  logic [9:0]  fill1_q, fill1_d;
  logic        pend_q, pend_d;
  logic [9:0]  pend_line_q, pend_line_d;
  logic [8:0]  word_q, word_d;
  logic [9:0]  fetch_s_q, fetch_s_d;
  logic        fetch_buf_q, fetch_buf_d;
  logic        stale_q, stale_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  pix_y_q, pix_y_d;
  logic [7:0]  pix_u_q, pix_u_d;
  logic [7:0]  pix_v_q, pix_v_d;
  logic [7:0]  pix_aux_q, pix_aux_d;

  logic [63:0] line_mem [0:1023];

  logic [11:0] next_line;
  logic        line_change;
  logic        sched_ok;
  logic        wr_en;
  logic        last_word;
  logic        stop_fetch;
  logic        start_fetch;
  logic        advance;
  logic [19:0] start_idx;

  assign next_line   = pixPosY + 12'd1;
  assign line_change = (pixPosY != prev_y_q);
  assign sched_ok    = (next_line < line_h);
  assign wr_en       = (state_q == ST_REQ) && mem.memAck;
  assign last_word   = ({1'b0, word_q} == (fetch_s_q - 10'd1));
  // An accepted word ends the fetch early if enable dropped or the line moved on.
  assign stop_fetch  = !fetch_en || line_change || stale_q;
  assign start_fetch = (state_q == ST_IDLE) && (state_d == ST_REQ);
  assign advance     = wr_en && (state_d == ST_REQ);
  assign start_idx   = {10'd0, pend_line_q} * {10'd0, words_per_line};

  // Fetch FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Hold off a start in the swap cycle, so the target buffer is the post-swap back.
      ST_IDLE: if (pend_q && fetch_en && !line_change) state_d = ST_REQ;
      ST_REQ: begin
        if (mem.memAck) begin
          if (last_word)       state_d = ST_DONE;
          else if (stop_fetch) state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch FSM outputs: request level and the held address.
  always_comb begin
    mem.memReq  = (state_q == ST_REQ);
    mem.memAddr = addr_q;
  end

  // Scheduling, fetch bookkeeping and buffer swap.
  always_comb begin
    prev_y_d    = pixPosY;
    front_d     = line_change ? ~front_q : front_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    word_d      = word_q;
    fetch_s_d   = fetch_s_q;
    fetch_buf_d = fetch_buf_q;
    stale_d     = stale_q;
    addr_d      = addr_q;
    if (start_fetch) begin
      pend_d      = 1'b0;
      word_d      = 9'd0;
      fetch_s_d   = words_per_line;
      fetch_buf_d = ~front_q;
      stale_d     = 1'b0;
      addr_d      = fb_base + {9'd0, start_idx, 3'b000};
    end else if (advance) begin
      word_d = word_q + 9'd1;
      addr_d = addr_q + 32'd8;
    end
    if (line_change) begin
      pend_d      = sched_ok;
      pend_line_d = next_line[9:0];
      if (state_q == ST_REQ) stale_d = 1'b1;
    end
  end

  // Fill counts: count accepted words; the buffer swapped to the back starts empty.
  always_comb begin
    fill0_d = fill0_q;
    fill1_d = fill1_q;
    if (wr_en) begin
      if (fetch_buf_q) fill1_d = fill1_q + 10'd1;
      else             fill0_d = fill0_q + 10'd1;
    end
    if (line_change) begin
      if (front_q) fill1_d = 10'd0;
      else         fill0_d = 10'd0;
    end
  end

  logic [9:0]  front_fill;
  logic [63:0] rd_data;
  logic [31:0] rd_pix;
  logic        visible;
  logic        underrun;

  // Pixel lookup in the front buffer with blanking for off-screen, disabled or unfilled.
  always_comb begin
    front_fill = front_q ? fill1_q : fill0_q;
    rd_data    = line_mem[{front_q, pixPosX[9:1]}];
    rd_pix     = pixPosX[0] ? rd_data[63:32] : rd_data[31:0];
    visible    = fetch_en && (pixPosX < line_w) && (pixPosY < line_h);
    underrun   = visible && ({1'b0, pixPosX[9:1]} >= front_fill);
    pix_y_d    = 8'd0;
    pix_u_d    = 8'd128;
    pix_v_d    = 8'd128;
    pix_aux_d  = 8'd0;
    if (visible && !underrun) begin
      pix_y_d   = rd_pix[7:0];
      pix_u_d   = rd_pix[15:8];
      pix_v_d   = rd_pix[23:16];
      pix_aux_d = rd_pix[31:24];
    end
  end

  // Line buffer write port; the contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) line_mem[{fetch_buf_q, word_q}] <= mem.memData;
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_y_q    <= 12'd0;
      front_q     <= 1'b0;
      fill0_q     <= 10'd0;
      fill1_q     <= 10'd0;
      pend_q      <= 1'b0;
      pend_line_q <= 10'd0;
      word_q      <= 9'd0;
      fetch_s_q   <= 10'd0;
      fetch_buf_q <= 1'b0;
      stale_q     <= 1'b0;
      addr_q      <= 32'd0;
      pix_y_q     <= 8'd0;
      pix_u_q     <= 8'd128;
      pix_v_q     <= 8'd128;
      pix_aux_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_y_q    <= prev_y_d;
      front_q     <= front_d;
      fill0_q     <= fill0_d;
      fill1_q     <= fill1_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      word_q      <= word_d;
      fetch_s_q   <= fetch_s_d;
      fetch_buf_q <= fetch_buf_d;
      stale_q     <= stale_d;
      addr_q      <= addr_d;
      pix_y_q     <= pix_y_d;
      pix_u_q     <= pix_u_d;
      pix_v_q     <= pix_v_d;
      pix_aux_q   <= pix_aux_d;
    end
  end

  assign pixCy  = pix_y_q;
  assign pixCu  = pix_u_q;
  assign pixCv  = pix_v_q;
  assign pixAux = {8'h00, pix_aux_q};

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
  logic [15:0] under_q, under_d;

  // Underrun counter saturates at full scale.
  always_comb begin
    under_d = under_q;
    if (underrun && (under_q != 16'hFFFF)) under_d = under_q + 16'd1;
  end

  // Underrun counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) under_q <= 16'd0;
    else       under_q <= under_d;
  end

  assign underrunCnt = under_q;
`else
  assign underrunCnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: scoreboard bench for vga_line_fetch.
// Memory returns a fixed hash of the address, so every pixel is predictable.
// The model tracks which line each buffer holds and how many words have landed.
module tb_vga_line_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [63:0] ctrl;
  logic [7:0]  cy, cu, cv;
  logic [15:0] aux, ucnt;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_mode = 1;

  vga_line_fetch_if bus();

  vga_line_fetch dut (
    .clock(clock), .reset(reset), .pixPosX(pix_x), .pixPosY(pix_y),
    .ctrlRegVal(ctrl), .mem(bus.master), .pixCy(cy), .pixCu(cu), .pixCv(cv),
    .pixAux(aux), .underrunCnt(ucnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] img(input logic [31:0] a);
    logic [31:0] lo, hi;
    lo = a * 32'h9E3779B1;
    hi = (a ^ 32'h00FF00FF) * 32'h85EBCA6B;
    return {hi, lo};
  endfunction

  assign bus.memData = img(bus.memAddr);

  typedef struct { int line; int word; logic [31:0] addr; } req_t;
  typedef struct { int stamp; logic [7:0] y; logic [7:0] u; logic [7:0] v; logic [15:0] aux; } pix_t;
  req_t req_q[$];
  pix_t pix_q[$];
  int m_line[2];
  int m_fill[2];
  int m_s[2];
  int m_front, m_prev_y, m_under;
  req_t mon_r;
  pix_t mon_p;

  function automatic int cur_w(); return ctrl[3] ? 800 : 640; endfunction
  function automatic int cur_h(); return ctrl[3] ? 600 : 480; endfunction
  function automatic int cur_s(); return ctrl[3] ? 400 : 320; endfunction
  function automatic logic [31:0] base(); return {ctrl[63:35], 3'b000}; endfunction

  function automatic int rand_x();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return $urandom_range(0, cur_w() - 1);
    if (r == 7) return cur_w();
    if (r == 8) return $urandom_range(cur_w(), 4095);
    return 3840 + $urandom_range(0, 255);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_under(input string name);
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    check(name, 64'(ucnt), 64'(m_under));
`else
    check(name, 64'(ucnt), 64'd0);
`endif
  endtask

  // Drive one scan position. The pixel is predicted from the pre-swap model state;
  // a line change then swaps the model and queues the nreq addresses expected.
  task automatic step(input int x, input int y, input int nreq);
    pix_t p;
    req_t r;
    int f, b, n, word;
    logic [63:0] d;
    logic [31:0] px;
    p.stamp = cyc; p.y = 8'd0; p.u = 8'd128; p.v = 8'd128; p.aux = 16'd0;
    f = m_front;
    word = x / 2;
    if (ctrl[0] && x < cur_w() && y < cur_h()) begin
      if (word >= m_fill[f]) begin
        if (m_under < 65535) m_under++;
      end else begin
        d = img(base() + 32'((m_line[f] * m_s[f] + word) * 8));
        px = (x % 2 == 1) ? d[63:32] : d[31:0];
        p.y = px[7:0]; p.u = px[15:8]; p.v = px[23:16]; p.aux = {8'h00, px[31:24]};
      end
    end
    pix_q.push_back(p);
    if (y != m_prev_y) begin
      m_front = 1 - m_front;
      b = 1 - m_front;
      m_fill[b] = 0;
      n = (y + 1) % 4096;
      if (n < cur_h()) begin
        m_line[b] = n;
        m_s[b] = cur_s();
        if (ctrl[0]) begin
          for (int w = 0; w < nreq; w++) begin
            r.line = n; r.word = w; r.addr = base() + 32'((n * cur_s() + w) * 8);
            req_q.push_back(r);
          end
        end
      end else begin
        m_line[b] = -1;
      end
      m_prev_y = y;
    end
    pix_x = 12'(x);
    pix_y = 12'(y);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int y);
    int n;
    n = 0;
    while ((req_q.size() != 0 || bus.memReq) && n < 3000) begin
      step(rand_x(), y, 0);
      n++;
    end
    check("fetch_within_budget", 64'(n < 3000), 64'd1);
  endtask

  // memAck driver: 0 = held low, 1 = held high, otherwise random.
  initial begin
    bus.memAck = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ack_mode)
        0:       bus.memAck = 1'b0;
        1:       bus.memAck = 1'b1;
        default: bus.memAck = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Request monitor: every accepted handshake must match the next expected address.
  always @(negedge clock) begin
    if (!reset && bus.memReq && bus.memAck) begin
      total++;
      if (req_q.size() == 0) begin
        bad++;
        $display("FAIL req_unexpected got addr=%h want no request", bus.memAddr);
      end else begin
        mon_r = req_q.pop_front();
        if (bus.memAddr !== mon_r.addr) begin
          bad++;
          $display("FAIL req_addr got=%h want=%h (line %0d word %0d)", bus.memAddr, mon_r.addr, mon_r.line, mon_r.word);
        end
        if (m_line[0] == mon_r.line) m_fill[0] = mon_r.word + 1;
        else                         m_fill[1] = mon_r.word + 1;
      end
    end
  end

  // Pixel monitor: compares the output one cycle after each scan position was sampled.
  always @(negedge clock) begin
    while (pix_q.size() > 0 && pix_q[0].stamp == cyc - 1) begin
      mon_p = pix_q.pop_front();
      total++;
      if ({cy, cu, cv, aux} !== {mon_p.y, mon_p.u, mon_p.v, mon_p.aux}) begin
        bad++;
        $display("FAIL pixel got y=%0d u=%0d v=%0d aux=%h want y=%0d u=%0d v=%0d aux=%h",
                 cy, cu, cv, aux, mon_p.y, mon_p.u, mon_p.v, mon_p.aux);
      end
    end
  end

  initial begin
    reset = 1'b1;
    pix_x = 12'd0;
    pix_y = 12'd0;
    ctrl = {32'h0000_1000, 32'h0000_0001};
    m_line = '{-1, -1};
    m_fill = '{0, 0};
    m_s = '{320, 320};
    m_front = 0; m_prev_y = 0; m_under = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_memReq", 64'(bus.memReq), 64'd0);
    check("rst_memAddr", 64'(bus.memAddr), 64'd0);
    check("rst_pixCy", 64'(cy), 64'd0);
    check("rst_pixCu", 64'(cu), 64'd128);
    check("rst_pixCv", 64'(cv), 64'd128);
    check("rst_pixAux", 64'(aux), 64'd0);
    check("rst_underrun", 64'(ucnt), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 640 mode: fetch line 0, then line 1 from 0x1A00 while line 0 is scanned.
    ack_mode = 1;
    step(rand_x(), 4095, cur_s());
    wait_done(4095);
    check("line0_memReq_low", 64'(bus.memReq), 64'd0);
    ack_mode = 2;
    step(rand_x(), 0, cur_s());
    wait_done(0);
    check("line1_memReq_low", 64'(bus.memReq), 64'd0);
    step(5, 0, 0);
    step(640, 0, 0);
    step(4094, 0, 0);
    check_under("under_offscreen");
    repeat (40) step(rand_x(), 0, 0);
    ctrl[0] = 1'b0;
    repeat (8) step(rand_x(), 0, 0);
    ctrl[0] = 1'b1;
    step(rand_x(), 0, 0);

    // Ack held low, two line changes: first-line data is late and lands in its old buffer.
    ack_mode = 0;
    step(4095, 0, 0);
    step(0, 1, 1);
    step(4095, 1, 0);
    step(4095, 1, 0);
    check("stalled_memReq_high", 64'(bus.memReq), 64'd1);
    step(0, 2, cur_s());
    repeat (10) step(0, 2, 0);
    check_under("under_after_10");
    ack_mode = 1;
    wait_done(2);
    check_under("under_after_refill");

    // 800 mode: line 599 is fetched; a change to 599 schedules nothing.
    ack_mode = 2;
    ctrl[3] = 1'b1;
    step(rand_x(), 598, cur_s());
    wait_done(598);
    step(rand_x(), 599, 0);
    repeat (30) begin
      step(rand_x(), 599, 0);
      check("no_fetch_599", 64'(bus.memReq), 64'd0);
    end
    check_under("under_800");

    // Reset asserted mid-handshake drops memReq immediately.
    ack_mode = 0;
    step(4095, 0, 0);
    step(4095, 0, 0);
    step(4095, 0, 0);
    check("mid_memReq_high", 64'(bus.memReq), 64'd1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_memReq_drop", 64'(bus.memReq), 64'd0);
    check("async_memAddr", 64'(bus.memAddr), 64'd0);
    check("async_pix", 64'({cy, cu, cv, aux}), 64'({8'd0, 8'd128, 8'd128, 16'd0}));
    check("async_underrun", 64'(ucnt), 64'd0);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    check("pix_queue_drained", 64'(pix_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
